inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

Dual-ported instruction queue between `fetch_stage` and `issue_unit` in the superscalar core. Each cycle it accepts up to two fetched {pc, instruction} pairs in program order and presents up to two oldest entries to issue, decoupling fetch from issue stalls. A flush, on a taken branch or redirect, discards every queued entry.

## Interface
- `DEPTH`, default 8: number of entries. Must be a power of two and at least 4.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset asserted).
- `flush`  in  1  discard all entries; takes priority over push and pop.
- `in_valid_a`  in  1  fetch slot A valid (older instruction).
- `in_valid_b`  in  1  fetch slot B valid; only meaningful when `in_valid_a`=1.
- `in_pc_a`, `in_pc_b`  in  32 each  PCs of the fetched pair.
- `in_inst_a`, `in_inst_b`  in  32 each  fetched instruction words.
- `in_ready`  out  1  queue can accept two entries this cycle.
- `out_valid_a`  out  1  head entry valid.
- `out_valid_b`  out  1  head+1 entry valid.
- `out_pc_a`, `out_pc_b`  out  32 each  PCs of head and head+1.
- `out_inst_a`, `out_inst_b`  out  32 each  instruction words of head and head+1.
- `deq_cnt`  in  2  entries consumed by issue this cycle (0, 1 or 2).
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage is a circular buffer of DEPTH × {pc, inst}. It has `rd_ptr`, `wr_ptr` and `count` registers. Pointers wrap modulo DEPTH.
- Push count:
  - 0 if `in_valid_a`=0 or `in_ready`=0. `in_valid_b` alone is ignored.
  - 1 if only A is valid.
  - 2 if both A and B are valid.
- A is written at `wr_ptr`, B at `wr_ptr+1`. Then `wr_ptr` advances by the push count.
- `in_ready` = (DEPTH − `count`) ≥ 2, from registered `count` only. It has no combinational path from `deq_cnt`. Fetch must hold its pair when `in_ready`=0.
- Pop count = min(`deq_cnt`, `count`), with `deq_cnt`=3 treated as 2. Excess requests are silently clamped. `rd_ptr` advances by the pop count.
- Next `count` = `count` + push count − pop count. A simultaneous push and pop is legal in any combination.
- Outputs are combinational from registered state:
  - `out_valid_a` = (`count` ≥ 1).
  - `out_valid_b` = (`count` ≥ 2).
  - `out_*_a` reads entry `rd_ptr`; `out_*_b` reads entry `rd_ptr+1`.
  - A data output whose valid is 0 is driven to 0.
- Flush: next-cycle `count`=0 and `rd_ptr`=`wr_ptr`=0. Push and pop in the flush cycle are ignored. Storage contents are don't-care.
- Program order is preserved: head A is always older than head B, and in-slot A is older than in-slot B.

## Timing
- While `reset`=0, asynchronously: `count`=0, pointers=0, `in_ready`=1, `out_valid_a`=`out_valid_b`=0, and all `out_pc`/`out_inst`=0.
- Reset may be asserted mid-operation. All state clears immediately, and in-flight entries are lost.
- Latency: a pair pushed at edge N is visible on the outputs after edge N (one cycle, no bypass). An empty queue with a push shows nothing in the push cycle.
- A pop takes effect at the clock edge. The next entries appear in the following cycle.
- Full boundary: at `count` = DEPTH−1 or DEPTH, `in_ready`=0, even if the same cycle pops.
- Empty boundary: at `count`=0, `deq_cnt`≠0 has no effect and `count` stays 0.
- Wrap-around: a 2-entry push with `wr_ptr`=DEPTH−1 writes B to entry 0. The output pair reads likewise across the wrap.
- `count` never exceeds DEPTH or goes below 0.

## Test plan
Default DEPTH=8 unless stated.
- **Reset and basic pass-through:** hold reset low, then release; push pc 0x100/0x104 with inst 0x00000013/0x00500093. Required: one cycle later `out_valid_a`=`out_valid_b`=1, `out_pc_a`=0x100, `out_pc_b`=0x104, `count`=2. With `deq_cnt`=2, the next cycle shows `count`=0 and both valids 0.
- **Fill to full:** push 4 pairs with no pops (`count`=8). Required: `in_ready`=0 from `count`=7 onward. A further push is held and not written. Popping 2 gives `count`=6 and `in_ready`=1 the next cycle.
- **Wrap and order:** with DEPTH=8, push 3 pairs and pop 5 singles, then push pairs 0x200–0x21C over the wrap. Required: the pop sequence of PCs is strictly increasing by 4, with no duplicates or gaps.
- **Simultaneous push/pop and clamping:** at `count`=1, drive a 2-push with `deq_cnt`=2. Required: pop clamped to 1, `count`=2 next cycle, and the head is the first pushed PC. Drive `in_valid_b`=1 with `in_valid_a`=0: required no push.
- **Flush priority:** at `count`=5, assert `flush` with a 2-push and `deq_cnt`=1. Required: next cycle `count`=0, both valids 0, `in_ready`=1. A push the following cycle appears at the head.
- **Async reset mid-operation:** at `count`=4, drop `reset` between clock edges. Required: outputs clear immediately without a clock edge, and operation resumes normally after release.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
// Fetch/issue bundle for inst_fetch_queue.
// master drives fetch pair, flush and deq_cnt; slave is the queue.
interface inst_fetch_queue_if #(
  parameter int DEPTH = 8
);
  logic                     flush;
  logic                     in_valid_a;
  logic                     in_valid_b;
  logic [31:0]              in_pc_a;
  logic [31:0]              in_pc_b;
  logic [31:0]              in_inst_a;
  logic [31:0]              in_inst_b;
  logic                     in_ready;
  logic                     out_valid_a;
  logic                     out_valid_b;
  logic [31:0]              out_pc_a;
  logic [31:0]              out_pc_b;
  logic [31:0]              out_inst_a;
  logic [31:0]              out_inst_b;
  logic [1:0]               deq_cnt;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output flush, in_valid_a, in_valid_b,
    output in_pc_a, in_pc_b, in_inst_a, in_inst_b,
    output deq_cnt,
    input  in_ready, out_valid_a, out_valid_b,
    input  out_pc_a, out_pc_b, out_inst_a, out_inst_b,
    input  count
  );

  modport slave (
    input  flush, in_valid_a, in_valid_b,
    input  in_pc_a, in_pc_b, in_inst_a, in_inst_b,
    input  deq_cnt,
    output in_ready, out_valid_a, out_valid_b,
    output out_pc_a, out_pc_b, out_inst_a, out_inst_b,
    output count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Dual-ported circular instruction queue between fetch and issue.
// Up to two pushes and two pops per cycle; flush empties it.
module inst_fetch_queue #(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  inst_fetch_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] r_pc   [DEPTH];
  logic [31:0] r_inst [DEPTH];
  ptr_t        r_rd_ptr;
  ptr_t        r_wr_ptr;
  cnt_t        r_count;

  ptr_t        w_wr_ptr1;
  ptr_t        w_rd_ptr1;
  logic        w_ready;
  logic        w_push_a;
  logic        w_push_b;
  cnt_t        w_push_n;
  logic [1:0]  w_deq;
  cnt_t        w_pop_n;
  logic        w_val_a;
  logic        w_val_b;

  assign w_wr_ptr1 = r_wr_ptr + ptr_t'(1);
  assign w_rd_ptr1 = r_rd_ptr + ptr_t'(1);

  // Ready depends on registered occupancy only, never on deq_cnt.
  assign w_ready  = r_count <= cnt_t'(DEPTH - 2);
  assign w_push_a = bus.in_valid_a & w_ready & ~bus.flush;
  assign w_push_b = w_push_a & bus.in_valid_b;
  assign w_push_n = cnt_t'(w_push_a) + cnt_t'(w_push_b);

  assign w_deq   = (bus.deq_cnt == 2'd3) ? 2'd2 : bus.deq_cnt;
  assign w_pop_n = (cnt_t'(w_deq) > r_count) ? r_count
                                             : cnt_t'(w_deq);

  always_ff @(posedge clk) begin
    if (w_push_a) begin
      r_pc[r_wr_ptr]   <= bus.in_pc_a;
      r_inst[r_wr_ptr] <= bus.in_inst_a;
    end
    if (w_push_b) begin
      r_pc[w_wr_ptr1]   <= bus.in_pc_b;
      r_inst[w_wr_ptr1] <= bus.in_inst_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + ptr_t'(w_pop_n);
      r_wr_ptr <= r_wr_ptr + ptr_t'(w_push_n);
      r_count  <= r_count + w_push_n - w_pop_n;
    end
  end

  assign w_val_a = r_count != '0;
  assign w_val_b = r_count >= cnt_t'(2);

  assign bus.in_ready    = w_ready;
  assign bus.count       = r_count;
  assign bus.out_valid_a = w_val_a;
  assign bus.out_valid_b = w_val_b;
  assign bus.out_pc_a    = w_val_a ? r_pc[r_rd_ptr]    : '0;
  assign bus.out_inst_a  = w_val_a ? r_inst[r_rd_ptr]  : '0;
  assign bus.out_pc_b    = w_val_b ? r_pc[w_rd_ptr1]   : '0;
  assign bus.out_inst_b  = w_val_b ? r_inst[w_rd_ptr1] : '0;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: vector table plus
// wrap-order, flush and async-reset sequences.
module tb_inst_fetch_queue;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  inst_fetch_queue_if #(.DEPTH(8)) bus ();

  inst_fetch_queue #(.DEPTH(8)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        fl, va, vb;
    logic [31:0] pa, pb;
    logic [1:0]  dq;
    logic [31:0] cnt;
    logic        rdy, ova, ovb;
    logic [31:0] opa, opb;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] f(logic [31:0] pc);
    if (pc == 32'h100) return 32'h0000_0013;
    if (pc == 32'h104) return 32'h0050_0093;
    return pc ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t mk(
    logic fl, logic va, logic vb,
    logic [31:0] pa, logic [31:0] pb, logic [1:0] dq,
    logic [31:0] cnt, logic rdy, logic ova, logic ovb,
    logic [31:0] opa, logic [31:0] opb);
    vec_t v;
    v.fl = fl; v.va = va; v.vb = vb;
    v.pa = pa; v.pb = pb; v.dq = dq;
    v.cnt = cnt; v.rdy = rdy;
    v.ova = ova; v.ovb = ovb;
    v.opa = opa; v.opb = opb;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.flush      = 1'b0;
    bus.in_valid_a = 1'b0;
    bus.in_valid_b = 1'b0;
    bus.in_pc_a    = '0;
    bus.in_pc_b    = '0;
    bus.in_inst_a  = '0;
    bus.in_inst_b  = '0;
    bus.deq_cnt    = '0;
  endtask

  task automatic drive(logic fl, logic va, logic vb,
                       logic [31:0] pa, logic [31:0] pb,
                       logic [1:0] dq);
    bus.flush      = fl;
    bus.in_valid_a = va;
    bus.in_valid_b = vb;
    bus.in_pc_a    = pa;
    bus.in_pc_b    = pb;
    bus.in_inst_a  = f(pa);
    bus.in_inst_b  = f(pb);
    bus.deq_cnt    = dq;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty(string nm);
    chk({nm, "_cnt"}, 32'(bus.count), 0);
    chk({nm, "_rdy"}, 32'(bus.in_ready), 1);
    chk({nm, "_va"}, 32'(bus.out_valid_a), 0);
    chk({nm, "_vb"}, 32'(bus.out_valid_b), 0);
    chk({nm, "_pca"}, bus.out_pc_a, 0);
    chk({nm, "_pcb"}, bus.out_pc_b, 0);
    chk({nm, "_ia"}, bus.out_inst_a, 0);
    chk({nm, "_ib"}, bus.out_inst_b, 0);
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] pcn;
    logic        pushed;
    logic        pushed_b;
    int          c;
    vec_t        v;
    string       nm;

    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle();

    tbl.push_back(mk(0,1,1,'h100,'h104,0, 2,1,1,1,'h100,'h104));
    tbl.push_back(mk(0,0,0,0,0,2,         0,1,0,0,0,0));
    tbl.push_back(mk(0,1,1,'h110,'h114,0, 2,1,1,1,'h110,'h114));
    tbl.push_back(mk(0,1,1,'h118,'h11C,0, 4,1,1,1,'h110,'h114));
    tbl.push_back(mk(0,1,1,'h120,'h124,0, 6,1,1,1,'h110,'h114));
    tbl.push_back(mk(0,1,1,'h128,'h12C,0, 8,0,1,1,'h110,'h114));
    tbl.push_back(mk(0,1,1,'h130,'h134,0, 8,0,1,1,'h110,'h114));
    tbl.push_back(mk(0,1,1,'h130,'h134,2, 6,1,1,1,'h118,'h11C));
    tbl.push_back(mk(0,0,0,0,0,1,         5,1,1,1,'h11C,'h120));
    tbl.push_back(mk(0,1,1,'h130,'h134,0, 7,0,1,1,'h11C,'h120));
    tbl.push_back(mk(0,1,1,'h138,'h13C,1, 6,1,1,1,'h120,'h124));
    tbl.push_back(mk(0,0,0,0,0,3,         4,1,1,1,'h128,'h12C));
    tbl.push_back(mk(0,0,0,0,0,2,         2,1,1,1,'h130,'h134));
    tbl.push_back(mk(0,0,0,0,0,2,         0,1,0,0,0,0));
    tbl.push_back(mk(0,1,1,'h140,'h144,0, 2,1,1,1,'h140,'h144));
    tbl.push_back(mk(0,1,1,'h148,'h14C,0, 4,1,1,1,'h140,'h144));
    tbl.push_back(mk(0,1,0,'h150,'h154,0, 5,1,1,1,'h140,'h144));
    tbl.push_back(mk(1,1,1,'h160,'h164,1, 0,1,0,0,0,0));
    tbl.push_back(mk(0,1,1,'h170,'h174,0, 2,1,1,1,'h170,'h174));
    tbl.push_back(mk(0,0,0,0,0,1,         1,1,1,0,'h174,0));
    tbl.push_back(mk(0,1,1,'h180,'h184,2, 2,1,1,1,'h180,'h184));
    tbl.push_back(mk(0,0,1,'h190,'h194,0, 2,1,1,1,'h180,'h184));
    tbl.push_back(mk(0,0,0,0,0,2,         0,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,2,         0,1,0,0,0,0));

    #23;
    chk_empty("reset");
    tick();
    #2;
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      v = tbl[i];
      drive(v.fl, v.va, v.vb, v.pa, v.pb, v.dq);
      tick();
      nm = $sformatf("v%0d", i);
      chk({nm, "_cnt"}, 32'(bus.count), v.cnt);
      chk({nm, "_rdy"}, 32'(bus.in_ready), 32'(v.rdy));
      chk({nm, "_va"}, 32'(bus.out_valid_a), 32'(v.ova));
      chk({nm, "_vb"}, 32'(bus.out_valid_b), 32'(v.ovb));
      chk({nm, "_pca"}, bus.out_pc_a, v.opa);
      chk({nm, "_pcb"}, bus.out_pc_b, v.opb);
      chk({nm, "_ia"}, bus.out_inst_a, v.ova ? f(v.opa) : 0);
      chk({nm, "_ib"}, bus.out_inst_b, v.ovb ? f(v.opb) : 0);
    end
    idle();

    // Wrap: 3 pairs, 5 single pops, then 0x200.. across entry 0.
    bus.flush = 1'b1;
    tick();
    idle();
    exp_pc = 32'h1E8;
    pcn    = 32'h1E8;
    c      = 0;
    while (exp_pc < 32'h220 && c < 200) begin
      idle();
      pushed   = 1'b0;
      pushed_b = 1'b0;
      if (c >= 3 && bus.out_valid_a) begin
        bus.deq_cnt = 2'd1;
        chk("wrap_pc", bus.out_pc_a, exp_pc);
        chk("wrap_inst", bus.out_inst_a, f(exp_pc));
        exp_pc = exp_pc + 4;
      end
      if ((c < 3 || c >= 8) && pcn < 32'h220 && bus.in_ready) begin
        pushed   = 1'b1;
        pushed_b = (c < 3) ||
                   (pcn != 32'h200 && pcn + 4 < 32'h220);
        bus.in_valid_a = 1'b1;
        bus.in_valid_b = pushed_b;
        bus.in_pc_a    = pcn;
        bus.in_pc_b    = pcn + 4;
        bus.in_inst_a  = f(pcn);
        bus.in_inst_b  = f(pcn + 4);
      end
      tick();
      if (pushed) pcn = pcn + (pushed_b ? 8 : 4);
      c++;
    end
    idle();
    n_chk++;
    if (exp_pc != 32'h220) begin
      n_err++;
      $display("FAIL wrap_timeout: got %h want %h", exp_pc, 32'h220);
    end
    chk("wrap_end_cnt", 32'(bus.count), 0);

    // Async reset between edges at count=4.
    drive(0, 1, 1, 'h240, 'h244, 0);
    tick();
    drive(0, 1, 1, 'h248, 'h24C, 0);
    tick();
    idle();
    chk("pre_rst_cnt", 32'(bus.count), 4);
    chk("pre_rst_pca", bus.out_pc_a, 'h240);
    #2;
    rst_n = 1'b0;
    #1;
    chk_empty("arst");
    #3;
    rst_n = 1'b1;
    drive(0, 1, 1, 'h300, 'h304, 0);
    tick();
    idle();
    chk("post_rst_cnt", 32'(bus.count), 2);
    chk("post_rst_pca", bus.out_pc_a, 'h300);
    chk("post_rst_pcb", bus.out_pc_b, 'h304);
    chk("post_rst_ib", bus.out_inst_b, f('h304));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
